// File: rtl/add_serial_if.sv
// add_serial_if: start/busy/done handshake plus operand and result bus for add_serial.
//   start : request a new operation (master -> slave)
//   sub   : 0 = add, 1 = subtract a - b (master -> slave)
//   a, b  : N-bit operands (master -> slave)
//   busy  : operation in progress (slave -> master)
//   done  : one-cycle completion pulse (slave -> master)
//   out   : 2N-bit registered result (slave -> master)
interface add_serial_if #(
    parameter int unsigned N = 8
);
    logic           start;
    logic           sub;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] out;

    modport master (
        output start, sub, a, b,
        input  busy, done, out
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, out
    );
endinterface

// File: rtl/add_serial.sv
// add_serial: digit-serial add/subtract unit, W operand bits per clock.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : add_serial_if slave (start/sub/a/b in, busy/done/out out);
//           the interface N must match this module's N.
// An operation takes C = N/W clock edges after start is accepted. The
// result is zero-extended (add) or sign-extended (sub) to 2N bits.
module add_serial #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    add_serial_if.slave bus
);
    localparam int unsigned C  = N / W;
    localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned RW = 2 * N;

    // Digit width must tile the operand exactly.
    generate
        if (W < 1 || W > N || (N % W) != 0) begin : g_bad_param
            $fatal(1, "add_serial: W must divide N and satisfy 1 <= W <= N");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [N-1:0]    a_q, a_n;
    logic [N-1:0]    b_q, b_n;
    logic            sub_q, sub_n;
    logic            carry_q, carry_n;
    logic [N-1:0]    part_q, part_n;
    logic [RW-1:0]   out_q, out_n;
    logic            busy_q;
    logic            done_q;

    logic [W:0]      csum;
    logic [N-1:0]    part_final;
    logic            sign;

    // Operands shift right one digit per RUN cycle, so the current digit is
    // always in the low W bits; result digits shift in from the top, landing
    // at bits [counter*W +: W] once all C digits are in.
    always_comb begin
        csum       = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + (W+1)'(carry_q);
        part_final = (part_q >> W) | (N'(csum[W-1:0]) << (N - W));
        // On the last digit a_q[W-1]/b_q[W-1] hold the operand MSBs (b already
        // inverted), giving bit N of the sign-extended N+1-bit difference.
        sign       = a_q[W-1] ^ b_q[W-1] ^ csum[W];
    end

    // Next-state and datapath update.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        a_n     = a_q;
        b_n     = b_q;
        sub_n   = sub_q;
        carry_n = carry_q;
        part_n  = part_q;
        out_n   = out_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = RUN;
                    a_n     = bus.a;
                    b_n     = bus.sub ? ~bus.b : bus.b;
                    sub_n   = bus.sub;
                    carry_n = bus.sub;
                    cnt_n   = '0;
                    part_n  = '0;
                end else if (state_q == DONE) begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                a_n     = a_q >> W;
                b_n     = b_q >> W;
                carry_n = csum[W];
                part_n  = part_final;
                if (cnt_q == CW'(C - 1)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                    if (sub_q) begin
                        out_n = {{N{sign}}, part_final};
                    end else begin
                        out_n = RW'({csum[W], part_final});
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            part_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            a_q     <= a_n;
            b_q     <= b_n;
            sub_q   <= sub_n;
            carry_q <= carry_n;
            part_q  <= part_n;
            out_q   <= out_n;
            busy_q  <= (state_n == RUN);
            done_q  <= (state_n == DONE);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;
endmodule

// File: tb/tb_add_serial.sv
// tb_add_serial: directed self-checking bench for add_serial.
// dut2 uses N=8, W=2 (C=4); dut8 uses N=8, W=8 (C=1).
module tb_add_serial;
    logic clk;
    logic rst_n;

    add_serial_if #(.N(8)) bus2 ();
    add_serial_if #(.N(8)) bus8 ();

    add_serial #(.N(8), .W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    add_serial #(.N(8), .W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one start pulse that is accepted at the next rising edge (T0).
    task automatic start_op(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        if (sel) begin
            bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.sub = s;
        end else begin
            bus2.start = 1'b1; bus2.a = a; bus2.b = b; bus2.sub = s;
        end
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        bus8.start = 1'b0;
    endtask

    // Count negedges until done is seen; returns cycles and busy cycles seen.
    task automatic wait_done(input bit sel, output int lat, output int busy_cnt);
        logic d, bz;
        lat      = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            d  = sel ? bus8.done : bus2.done;
            bz = sel ? bus8.busy : bus2.busy;
            if (d) begin
                lat = i + 1;
                break;
            end
            if (bz) busy_cnt++;
        end
        if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input bit sel, input logic [7:0] a,
                          input logic [7:0] b, input logic s, input logic [15:0] exp);
        int lat, bc;
        start_op(sel, a, b, s);
        wait_done(sel, lat, bc);
        check({tag, "_lat"}, 32'(lat), sel ? 32'd2 : 32'd5);
        check({tag, "_out"}, 32'(sel ? bus8.out : bus2.out), 32'(exp));
    endtask

    initial begin
        int lat, bc;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus2.start = 1'b0; bus2.sub = 1'b0; bus2.a = '0; bus2.b = '0;
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out",  32'(bus2.out),  32'h0);
        check("rst_busy", 32'(bus2.busy), 32'h0);
        check("rst_done", 32'(bus2.done), 32'h0);

        // Add 200 + 100: 4 busy cycles, done, then result held
        start_op(1'b0, 8'd200, 8'd100, 1'b0);
        wait_done(1'b0, lat, bc);
        check("add_lat",  32'(lat), 32'd5);
        check("add_busy", 32'(bc),  32'd4);
        check("add_out",  32'(bus2.out), 32'h012C);
        check("add_done_busy", 32'(bus2.busy), 32'h0);
        @(negedge clk);
        check("add_done_drop", 32'(bus2.done), 32'h0);
        check("add_hold", 32'(bus2.out), 32'h012C);

        run_op("add_max", 1'b0, 8'd255, 8'd255, 1'b0, 16'h01FE);
        run_op("sub_neg", 1'b0, 8'd5,   8'd9,   1'b1, 16'hFFFC);
        run_op("sub_pos", 1'b0, 8'd9,   8'd5,   1'b1, 16'h0004);
        run_op("sub_ovf", 1'b0, 8'h80,  8'd1,   1'b1, 16'hFF7F);

        // start held two cycles: only one operation runs
        @(negedge clk);
        bus2.start = 1'b1; bus2.a = 8'd1; bus2.b = 8'd2; bus2.sub = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 bus2.start = 1'b0;
        wait_done(1'b0, lat, bc);
        check("hold2_lat", 32'(lat), 32'd4);
        check("hold2_out", 32'(bus2.out), 32'h0003);
        @(negedge clk);
        check("hold2_no2nd_busy", 32'(bus2.busy), 32'h0);
        @(negedge clk);
        check("hold2_no2nd_done", 32'(bus2.done), 32'h0);

        // start pulsed mid-RUN with new operands is ignored
        start_op(1'b0, 8'd10, 8'd20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus2.start = 1'b1; bus2.a = 8'd99; bus2.b = 8'd99; bus2.sub = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        wait_done(1'b0, lat, bc);
        check("midrun_lat", 32'(lat), 32'd3);
        check("midrun_out", 32'(bus2.out), 32'h001E);

        // Back-to-back: start in the DONE cycle
        start_op(1'b0, 8'd7, 8'd8, 1'b0);
        wait_done(1'b0, lat, bc);
        check("b2b_first_out", 32'(bus2.out), 32'h000F);
        bus2.start = 1'b1; bus2.a = 8'd50; bus2.b = 8'd3; bus2.sub = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        @(negedge clk);
        check("b2b_busy", 32'(bus2.busy), 32'h1);
        check("b2b_out_stable", 32'(bus2.out), 32'h000F);
        wait_done(1'b0, lat, bc);
        check("b2b_gap", 32'(lat + 1), 32'd5);
        check("b2b_second_out", 32'(bus2.out), 32'h002F);

        // Reset during chunk 2 discards the operation
        start_op(1'b0, 8'd100, 8'd27, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(bus2.busy), 32'h0);
        check("rstmid_out",  32'(bus2.out),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus2.done || bus2.busy) bc++;
        end
        check("rstmid_no_done", 32'(bc), 32'd0);
        run_op("rstmid_fresh", 1'b0, 8'd100, 8'd27, 1'b0, 16'h007F);

        // W=8, single-cycle operation
        run_op("w8_add", 1'b1, 8'd3, 8'd4, 1'b0, 16'h0007);
        run_op("w8_sub", 1'b1, 8'd5, 8'd9, 1'b1, 16'hFFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/add_serial.md
Name: add_serial

Overview:
- Multi-cycle, digit-serial add/subtract unit for the calculator datapath.
- Processes W operand bits per clock, so wide operands cost fewer adder cells at the price of N/W cycles of latency.
- Result is presented on the same 2N-bit result bus width used by the calculator's other arithmetic units.
- Start/busy/done handshake to the calculator control FSM.

Parameters:
- N, 8, operand width in bits.
- W, 2, bits processed per cycle (digit width). Requires N % W == 0 and 1 <= W <= N; otherwise elaboration fails.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; accepted only when busy=0.
- sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
- a  input  N  operand A, unsigned for add, two's complement for sub; sampled with start.
- b  input  N  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when out is updated.
- out  output  2N  registered result, held until the next completion.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, out=0, internal operand, carry and partial-result registers=0. Takes effect immediately, including mid-operation. The in-flight operation is discarded with no done pulse.
- C = N/W chunks per operation.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1. Chunk counter 0..C-1.
  - DONE: one cycle. done=1, busy=0.
- Transitions:
  - IDLE or DONE with start=1 at edge T0 -> RUN. Captures a, sub, and b (b inverted when sub=1). Carry-in initialised to sub. Counter=0.
  - DONE with start=0 -> IDLE.
  - RUN:
    - At each edge, chunk[counter] = A_chunk + B_chunk + carry, computed W bits wide.
    - The result chunk is written to partial-result bits [counter*W +: W], and carry is updated.
    - When counter=C-1, that same edge writes out and goes to DONE.
- Timing: start sampled at edge T0. busy=1 during cycles following edges T0..T0+C-1. out valid and done=1 during the cycle after edge T0+C. Total latency C edges after start acceptance.
- Result formatting:
  - add: out = zero-extend(a + b) to 2N. Bit N = final carry. Bits above N are 0.
  - sub: out = a - b as two's complement, sign-extended to 2N. The sign is taken from the true N+1-bit difference, with operands treated as signed N-bit. out[2N-1:N] replicates the difference sign.
- start while busy=1 is ignored entirely: no capture, and the operation in progress is unaffected.
- start in the DONE cycle is accepted: back-to-back operation with zero idle cycles. done still pulses for the finished operation in that cycle.
- Changes on a, b, sub after acceptance have no effect.
- out changes only at the completion edge (or on reset). Intermediate chunks are never visible on out.
- W=N degenerates to C=1: done one cycle after acceptance.
- Wrap-around: counter never exceeds C-1. Carry out of the top chunk is not fed into the next operation.

Test Plan (N=8, W=2 unless stated):
- Reset → after release: out=16'h0000, busy=0, done=0.
- Add, normal case: start with a=200, b=100, sub=0 → busy high for 4 cycles, then done pulse. out=16'h012C, held after done drops.
- Add, both operands at maximum: a=255, b=255 → out=16'h01FE.
- Subtract, both signs:
  - sub=1, a=5, b=9 → out=16'hFFFC.
  - sub=1, a=9, b=5 → out=16'h0004.
  - sub=1, a=8'h80 (-128), b=1 → out=16'hFF7F (-129).
- Handshake, back-to-back:
  - start asserted for 2 cycles at T0 → only one operation runs.
  - start pulsed again mid-RUN with different operands → ignored; result reflects the first operands.
  - start held in the DONE cycle → a second operation begins immediately, with a second done exactly 5 cycles after the first.
- Reset mid-RUN: rst_n low during chunk 2 → busy=0, out=0 immediately. No done pulse; a fresh start afterwards gives the correct result.
- W=8 (C=1): a=3, b=4 → done one cycle after start, out=16'h0007.
